// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic signed [2:0] booth_digit_t;

    // Radix-4 digits needed to cover a (width+1)-bit extended multiplier.
    function automatic int ndig(input int width);
        return (width + 2) / 2;
    endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder: three multiplier bits select 0, +/-x or +/-2x,
// returned sign-extended to the accumulator width.
module booth_r4_recode
    import booth_pkg::*;
#(
    parameter int WIDTH = 25
) (
    input  logic [2:0]       bits,
    input  logic [WIDTH:0]   x_ext,
    output logic [WIDTH+2:0] pp
);

    booth_digit_t     digit;
    logic [WIDTH+2:0] xs;
    logic [WIDTH+2:0] mag;

    always_comb begin
        xs = {{2{x_ext[WIDTH]}}, x_ext};
        unique case (bits)
            3'b001, 3'b010: digit = 3'sd1;
            3'b011:         digit = 3'sd2;
            3'b100:         digit = -3'sd2;
            3'b101, 3'b110: digit = -3'sd1;
            default:        digit = 3'sd0;
        endcase

        mag = '0;
        if (digit == 3'sd2 || digit == -3'sd2) begin
            mag = xs << 1;
        end else if (digit != 3'sd0) begin
            mag = xs;
        end
        pp = digit[2] ? -mag : mag;
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Optional macro BOOTH_ZERO_SKIP_EN: zero operands bypass iteration (latency 1).
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and a producer holds its data until transfer.

    localparam int NDIG = ndig(WIDTH);
    localparam int YW   = 2 * NDIG;          // multiplier bits consumed by NDIG digits
    localparam int AW   = WIDTH + 3;
    localparam int TW   = AW + YW + 1;
    localparam int CW   = $clog2(NDIG + 1);

    state_t             state, state_nx;
    logic [AW-1:0]      acc, acc_nx, pp, sum;
    logic [YW:0]        y_sh, y_nx;          // bit 0 is the appended y[-1]
    logic [WIDTH:0]     x_ext;
    logic [CW-1:0]      cnt;
    logic [TW-1:0]      shifted;
    logic [YW-1:0]      y_in_ext;
    logic [2*WIDTH-1:0] prod_nx;
    logic               accept, last_dig, zero_op;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign last_dig = (cnt == CW'(NDIG - 1));

`ifdef BOOTH_ZERO_SKIP_EN
    assign zero_op = (x == '0) || (y == '0);
`else
    assign zero_op = 1'b0;
`endif

    booth_r4_recode #(.WIDTH(WIDTH)) u_recode (
        .bits  (y_sh[2:0]),
        .x_ext (x_ext),
        .pp    (pp)
    );

    always_comb begin
        y_in_ext = {{(YW - WIDTH){in_signed & y[WIDTH-1]}}, y};
        sum      = acc + pp;
        shifted  = $signed({sum, y_sh}) >>> 2;
        acc_nx   = shifted[TW-1 -: AW];
        y_nx     = shifted[YW:0];
        // Low product bits have been shifted into the multiplier register.
        prod_nx  = {acc_nx[2*WIDTH-YW-1:0], y_nx[YW:1]};
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = zero_op ? DONE : BUSY;
            BUSY:    if (last_dig) state_nx = DONE;
            DONE:    if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            y_sh      <= '0;
            x_ext     <= '0;
            cnt       <= '0;
            p         <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        x_ext <= {in_signed & x[WIDTH-1], x};
                        y_sh  <= {y_in_ext, 1'b0};
                        acc   <= '0;
                        cnt   <= '0;
                        if (zero_op) p <= '0;
                    end
                end
                BUSY: begin
                    acc  <= acc_nx;
                    y_sh <= y_nx;
                    cnt  <= cnt + 1'b1;
                    if (last_dig) begin
                        p         <= prod_nx;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Zero-skip enters DONE with out_valid low; raise it one edge later.
                    if (!out_valid)     out_valid <= 1'b1;
                    else if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult (WIDTH=25 and WIDTH=8 instances).
module tb_booth_seq_mult;

    localparam int W   = 25;
    localparam int W8  = 8;
    localparam int ND  = 13;
    localparam int ND8 = 5;
`ifdef BOOTH_ZERO_SKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_ready, in_signed = 1'b0, out_valid, out_ready = 1'b0;
    logic [W-1:0]  x = '0, y = '0;
    logic [2*W-1:0] p;
    logic          in_valid8 = 1'b0, in_ready8, in_signed8 = 1'b0, out_valid8, out_ready8 = 1'b0;
    logic [W8-1:0] x8 = '0, y8 = '0;
    logic [2*W8-1:0] p8;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    booth_seq_mult #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready), .p(p)
    );

    booth_seq_mult #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .in_signed(in_signed8),
        .x(x8), .y(y8), .out_valid(out_valid8), .out_ready(out_ready8), .p(p8)
    );

    // Reference: plain multiplication of the interpreted operands, truncated to 2w bits.
    function automatic logic [63:0] model(bit sgn, logic [63:0] a, logic [63:0] b, int w);
        logic [63:0] mask, sa, sb, pr;
        mask = (64'd1 << w) - 64'd1;
        sa = a & mask;
        sb = b & mask;
        if (sgn && sa[w-1]) sa = sa | ~mask;
        if (sgn && sb[w-1]) sb = sb | ~mask;
        pr = sa * sb;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return pr & mask;
    endfunction

    function automatic int exp_lat(bit is_zero, int nd);
        return (is_zero && ZSKIP) ? 1 : nd;
    endfunction

    // Driver: one operation on the 25-bit unit, operands scrambled after acceptance.
    task automatic op25(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] prod, output int lat);
        int c;
        @(negedge clk);
        in_signed = sgn; x = a; y = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; x = W'($urandom); y = W'($urandom); in_signed = ~sgn;
        lat = -1; prod = '0; c = 0;
        while (lat < 0 && c < 40) begin
            @(posedge clk); #1;
            c++;
            if (out_valid) begin
                lat = c;
                prod = p;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic op8(input bit sgn, input logic [W8-1:0] a, input logic [W8-1:0] b,
                       output logic [2*W8-1:0] prod, output int lat);
        int c;
        @(negedge clk);
        in_signed8 = sgn; x8 = a; y8 = b; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0; x8 = W8'($urandom); y8 = W8'($urandom); in_signed8 = ~sgn;
        lat = -1; prod = '0; c = 0;
        while (lat < 0 && c < 40) begin
            @(posedge clk); #1;
            c++;
            if (out_valid8) begin
                lat = c;
                prod = p8;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || p !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: out_valid=%b p=%0h expected 0/0", out_valid, p);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || in_ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready=%b in_ready8=%b expected 1", in_ready, in_ready8);
        end
        n_checks++;
        if (out_valid8 !== 1'b0 || p8 !== '0) begin
            n_fail++;
            $display("FAIL reset_w8: out_valid8=%b p8=%0h expected 0/0", out_valid8, p8);
        end
    endtask

    task automatic test_directed;
        bit           ds[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] dx[5] = '{25'd5, 25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF, 25'h1000000};
        logic [W-1:0] dy[5] = '{25'd6, 25'h1FFFFFF, 25'd1, 25'h1FFFFFF, 25'h1000000};
        logic [2*W-1:0] dp[5] = '{50'd30, 50'd1, 50'h3FFFFFFFFFFFF, 50'h3FFFFFC000001, 50'h1000000000000};
        logic [2*W-1:0] got;
        int lat;
        for (int i = 0; i < 5; i++) begin
            op25(ds[i], dx[i], dy[i], got, lat);
            n_checks++;
            if (got !== dp[i]) begin
                n_fail++;
                $display("FAIL directed_%0d: p=%0h expected %0h", i, got, dp[i]);
            end
            n_checks++;
            if (lat != ND) begin
                n_fail++;
                $display("FAIL directed_lat_%0d: latency=%0d expected %0d", i, lat, ND);
            end
        end
    endtask

    task automatic test_zero;
        logic [2*W-1:0] got;
        int lat;
        op25(1'b1, '0, W'($urandom) | 25'd1, got, lat);
        n_checks++;
        if (got !== '0 || lat != exp_lat(1'b1, ND)) begin
            n_fail++;
            $display("FAIL zero_x: p=%0h lat=%0d expected 0 lat=%0d", got, lat, exp_lat(1'b1, ND));
        end
        op25(1'b0, W'($urandom) | 25'd1, '0, got, lat);
        n_checks++;
        if (got !== '0 || lat != exp_lat(1'b1, ND)) begin
            n_fail++;
            $display("FAIL zero_y: p=%0h lat=%0d expected 0 lat=%0d", got, lat, exp_lat(1'b1, ND));
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0]   a, b, a2, b2;
        bit             s, s2;
        logic [2*W-1:0] held, expv;
        logic [63:0]    m;
        int             c;
        a = W'($urandom) | 25'd1; b = W'($urandom) | 25'd1; s = 1'($urandom);
        a2 = W'($urandom) | 25'd2; b2 = W'($urandom) | 25'd2; s2 = 1'($urandom);
        @(negedge clk);
        in_signed = s; x = a; y = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        c = 0;
        while (!out_valid && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        n_checks++;
        if (c != ND) begin
            n_fail++;
            $display("FAIL bp_latency: latency=%0d expected %0d", c, ND);
        end
        held = p;
        m = model(s, 64'(a), 64'(b), W);
        expv = m[2*W-1:0];
        n_checks++;
        if (held !== expv) begin
            n_fail++;
            $display("FAIL bp_product: p=%0h expected %0h", held, expv);
        end
        in_valid = 1'b1; in_signed = s2; x = a2; y = b2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || p !== held) begin
                n_fail++;
                $display("FAIL bp_stall_%0d: out_valid=%b in_ready=%b p=%0h expected 1/0/%0h",
                         i, out_valid, in_ready, p, held);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || p !== held) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b p=%0h expected 0/%0h", out_valid, p, held);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept_after: in_ready=%b expected 0", in_ready);
        end
        c = 0;
        while (!out_valid && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        m = model(s2, 64'(a2), 64'(b2), W);
        expv = m[2*W-1:0];
        n_checks++;
        if (c != ND || p !== expv) begin
            n_fail++;
            $display("FAIL bp_second: p=%0h lat=%0d expected %0h lat=%0d", p, c, expv, ND);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        logic [2*W-1:0] got;
        int lat;
        bit saw;
        @(negedge clk);
        in_signed = 1'b1; x = W'($urandom) | 25'd1; y = W'($urandom) | 25'd1;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || p !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: out_valid=%b p=%0h expected 0/0", out_valid, p);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ready: in_ready=%b expected 1", in_ready);
        end
        rst = 1'b0;
        saw = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) saw = 1'b1;
        end
        n_checks++;
        if (saw) begin
            n_fail++;
            $display("FAIL midrst_no_result: out_valid seen=%b expected 0", saw);
        end
        op25(1'b0, 25'd19, 25'hFF, got, lat);
        n_checks++;
        if (got !== 50'd4845 || lat != ND) begin
            n_fail++;
            $display("FAIL midrst_next_op: p=%0d lat=%0d expected 4845 lat=%0d", got, lat, ND);
        end
    endtask

    task automatic test_random25;
        logic [W-1:0]   a, b;
        bit             s;
        logic [2*W-1:0] got;
        logic [63:0]    e;
        int             lat;
        for (int i = 0; i < 30; i++) begin
            a = W'($urandom); b = W'($urandom); s = 1'($urandom_range(0, 1));
            exp_q.push_back(model(s, 64'(a), 64'(b), W));
            op25(s, a, b, got, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (64'(got) !== e || lat != exp_lat(a == '0 || b == '0, ND)) begin
                n_fail++;
                $display("FAIL rand25_%0d: s=%b x=%0h y=%0h p=%0h lat=%0d expected %0h lat=%0d",
                         i, s, a, b, got, lat, e, exp_lat(a == '0 || b == '0, ND));
            end
        end
    endtask

    task automatic test_random8;
        bit            ts[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [W8-1:0] ta[4] = '{8'h80, 8'hFF, 8'h80, 8'h7F};
        logic [W8-1:0] tb[4] = '{8'h80, 8'hFF, 8'h7F, 8'hFF};
        logic [W8-1:0] a, b;
        bit            s;
        logic [2*W8-1:0] got;
        logic [63:0]   e;
        int            lat;
        for (int i = 0; i < 24; i++) begin
            if (i < 4) begin
                a = ta[i]; b = tb[i]; s = ts[i];
            end else begin
                a = W8'($urandom); b = W8'($urandom); s = 1'($urandom_range(0, 1));
            end
            exp_q.push_back(model(s, 64'(a), 64'(b), W8));
            op8(s, a, b, got, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (64'(got) !== e || lat != exp_lat(a == '0 || b == '0, ND8)) begin
                n_fail++;
                $display("FAIL rand8_%0d: s=%b x=%0h y=%0h p=%0h lat=%0d expected %0h lat=%0d",
                         i, s, a, b, got, lat, e, exp_lat(a == '0 || b == '0, ND8));
            end
        end
    endtask

    task automatic test_back_to_back;
        int accepted = 0, done = 0, cyc = 0, last_acc = -1;
        logic [W-1:0] a, b;
        bit s;
        logic [63:0] e;
        exp_q.delete();
        out_ready = 1'b1;
        while (done < 6 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
                done++;
                n_checks++;
                if (64'(p) !== e) begin
                    n_fail++;
                    $display("FAIL b2b_result_%0d: p=%0h expected %0h", done, p, e);
                end
            end
            if (accepted < 6) begin
                a = W'($urandom) | 25'd4; b = W'($urandom) | 25'd4; s = 1'($urandom_range(0, 1));
                in_valid = 1'b1; in_signed = s; x = a; y = b;
                if (in_ready) begin
                    exp_q.push_back(model(s, 64'(a), 64'(b), W));
                    accepted++;
                    if (last_acc >= 0) begin
                        n_checks++;
                        if (cyc - last_acc < ND + 1) begin
                            n_fail++;
                            $display("FAIL b2b_gap: gap=%0d expected >= %0d", cyc - last_acc, ND + 1);
                        end
                    end
                    last_acc = cyc;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (done != 6) begin
            n_fail++;
            $display("FAIL b2b_timeout: completed=%0d expected 6", done);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_random25();
        test_random8();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
